uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit buffer between the processor's output-port write path and the UART transmit engine. The processor writes bytes in bursts through port 0. The block queues them and feeds the transmit engine one byte at a time. Each byte goes out with a single-cycle load pulse, issued only when the engine reports ready. Status outputs (full/empty/level/overflow) are meant to be folded into the UART status byte and the interrupt logic.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
AW, 4, pointer width = log2(DEPTH); count width is AW+1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  push strobe (port-0 write_strobe qualified); one byte per cycle high
wr_data  in  8  byte to push (out_port[7:0])
flush  in  1  synchronous clear of queued (not yet loaded) bytes
ovf_clr  in  1  clears sticky overflow flag
tx_rdy  in  1  transmit engine ready/idle level
tx_load  out  1  single-cycle load pulse to transmit engine
tx_data  out  8  byte presented to transmit engine; held until next load
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  AW+1  bytes currently queued (0..DEPTH)
ovf  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high), all registered:
  - rd/wr pointers = 0, count = 0, empty = 1, full = 0, ovf = 0.
  - tx_load = 0, tx_data = 8'h00, FSM = IDLE.
  - Storage array is not reset.
- Storage: DEPTH x 8 register array. Pointers wrap modulo DEPTH (natural AW-bit rollover). count tracks occupancy, so full and empty are never ambiguous.
- Push: wr_en and (not full, or pop in the same cycle) -> write at wr_ptr, wr_ptr+1.
  - Push while full with no pop -> byte dropped, pointers unchanged, ovf <= 1.
- Pop: only the drain FSM pops (see LOAD).
- Simultaneous push and pop -> count unchanged, both pointers advance. Legal at full and at empty+1.
- Push into an empty FIFO: byte becomes visible to the drain FSM the next cycle.
  - Minimum latency from wr_en (cycle N) to tx_load: tx_load high in cycle N+2 when IDLE and tx_rdy = 1.
- Drain FSM, states IDLE, LOAD, WAIT_BUSY, WAIT_RDY:
  - IDLE: if !empty and tx_rdy -> LOAD.
  - LOAD, one cycle:
    - tx_data <= mem[rd_ptr], tx_load <= 1 (registered; high for exactly the following cycle).
    - Pop: rd_ptr+1, count-1.
    - -> WAIT_BUSY.
  - WAIT_BUSY: wait for tx_rdy = 0 (engine accepted the byte), then -> WAIT_RDY. tx_load is 0 in every cycle except the one after LOAD.
  - WAIT_RDY: wait for tx_rdy = 1 (engine done), then -> IDLE.
  - The WAIT_BUSY/WAIT_RDY sequence guarantees no second load while a stale ready level lingers after the first load.
- flush:
  - Next cycle: rd_ptr <= wr_ptr, count <= 0, empty <= 1.
  - Any byte already loaded (FSM in WAIT_BUSY/WAIT_RDY) completes normally. FSM does not reset.
  - flush and wr_en in the same cycle -> flush wins; byte discarded, ovf not set.
  - flush in the same cycle as the LOAD pop -> the pop completes (byte is sent) and the FIFO is then empty.
- ovf is sticky until ovf_clr or reset. A new overflow in the same cycle as ovf_clr -> ovf = 1 (set wins).
- full, empty and count are registered and consistent with each other every cycle.
- Reset mid-transmission: FIFO contents are lost and FSM returns to IDLE. The transmit engine is reset by the same signal.

Decomposition:
- Shared package uart_pkg:
  - port-ID constants (UART_DATA_PORT = 16'h0000, UART_STATUS_PORT = 16'h0001)
  - status-bit index constants, including new TXF_FULL and TXF_OVF bits for the status byte
  - drain FSM state encoding typedef (2-bit)
- One natural sub-module: sync_fifo_core, holding storage, pointers, count, full/empty and the ovf flag. uart_tx_fifo adds the drain FSM and the flush/handshake rules on top.

Test Plan:
- Single byte:
  - Stimulus: reset, tx_rdy = 1; push 8'hA5 at cycle N; engine model drops tx_rdy 1 cycle after the load, raises it 20 cycles later.
  - Required: tx_load high only in cycle N+2 with tx_data = A5; empty = 1 at N+3; no second tx_load.
- Burst with back-pressure:
  - Stimulus: push 8'h01..8'h05 on consecutive cycles; engine busy for 10 cycles per byte.
  - Required: five tx_load pulses carrying 01..05 in order; count peaks at 4 or 5; every tx_load lands only in IDLE->LOAD with tx_rdy = 1.
- Overflow:
  - Stimulus: tx_rdy = 0; push 17 bytes (DEPTH = 16).
  - Required: full = 1 after byte 16; byte 17 dropped; ovf = 1; count = 16. ovf_clr -> ovf = 0. ovf_clr coincident with a further full push -> ovf stays 1.
- Wrap-around:
  - Stimulus: 40 bytes of an incrementing pattern, pushed and drained interleaved.
  - Required: output sequence identical to input; pointers wrap without loss or duplication; simultaneous push/pop at full keeps count = 16.
- Flush:
  - Stimulus: queue 6 bytes; assert flush while the first byte is in WAIT_RDY; push 8'h3C in the same cycle as flush.
  - Required: first byte's transmission completes; count = 0, empty = 1; 8'h3C never loaded; ovf unchanged.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges while in WAIT_BUSY with 3 bytes queued.
  - Required: tx_load = 0, tx_data = 00, count = 0, empty = 1, ovf = 0, all immediately; normal operation after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: port IDs, status-byte bit positions and the
// transmit drain state encoding used by the TX FIFO.
package uart_pkg;

    localparam logic [15:0] UART_DATA_PORT   = 16'h0000;
    localparam logic [15:0] UART_STATUS_PORT = 16'h0001;

    // Bit positions inside the status byte returned on UART_STATUS_PORT.
    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_RX_OVF    = 1;
    localparam int STAT_TX_BUSY   = 2;
    localparam int STAT_TXF_EMPTY = 3;
    localparam int TXF_FULL       = 4;
    localparam int TXF_OVF        = 5;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_RDY  = 2'd3
    } tx_state_e;

    // Places the TX FIFO flags at their status-byte positions; other bits zero.
    function automatic logic [7:0] txf_status_bits(input logic full,
                                                   input logic empty,
                                                   input logic ovf);
        logic [7:0] s;
        s                 = '0;
        s[STAT_TXF_EMPTY] = empty;
        s[TXF_FULL]       = full;
        s[TXF_OVF]        = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side and transmit-engine-side signals of the UART TX FIFO.
// The slave modport is the FIFO; master is the processor/engine side.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          ovf_clr;
    logic          tx_rdy;
    logic          tx_load;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_rdy,
        input  tx_load, tx_data, full, empty, count, ovf
    );

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_rdy,
        output tx_load, tx_data, full, empty, count, ovf
    );
endinterface

// File: rtl/sync_fifo_core.sv
// Byte FIFO core: storage, wrapping pointers, occupancy count, registered
// full/empty flags and a sticky overflow flag. DEPTH must equal 2**AW.
module sync_fifo_core #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          clr,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          push_ok;
    logic          push_drop;

    always_comb begin
        // A clear discards the incoming byte rather than queueing it.
        push_ok   = push && !clr && (!full_q || pop);
        push_drop = push && !clr && full_q && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (clr) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);

        // A fresh overflow outranks a coincident clear.
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues processor bytes and hands them to the
// transmit engine one at a time with a single-cycle load pulse.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    import uart_pkg::*;

    tx_state_e   state_q;
    logic        tx_load_q;
    logic [7:0]  tx_data_q;

    logic [7:0]  fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        fifo_ovf;
    logic        pop;

    // The pop and the load register update share the IDLE->LOAD edge, so a
    // byte pushed in cycle N is on tx_load in cycle N+2.
    assign pop = (state_q == TX_IDLE) && !fifo_empty && bus.tx_rdy;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .clr       (bus.flush),
        .ovf_clr   (bus.ovf_clr),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .ovf       (fifo_ovf)
    );

    // WAIT_BUSY then WAIT_RDY: a ready level still high right after a load
    // must first drop before the engine counts as free again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            tx_load_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_load_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        state_q   <= TX_LOAD;
                        tx_load_q <= 1'b1;
                        tx_data_q <= fifo_rd_data;
                    end
                end
                TX_LOAD: begin
                    state_q <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (!bus.tx_rdy) begin
                        state_q <= TX_WAIT_RDY;
                    end
                end
                TX_WAIT_RDY: begin
                    if (bus.tx_rdy) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_load = tx_load_q;
    assign bus.tx_data = tx_data_q;
    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;
    assign bus.count   = fifo_count;
    assign bus.ovf     = fifo_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model plus a simple
// transmit-engine model, checked every cycle on the falling edge.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic reset;

    uart_tx_fifo_if #(.AW(AW)) bus();

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    string tname    = "init";

    logic       s_wr, s_flush, s_clr, s_rdy;
    logic [7:0] s_data;

    bit eng_en;
    bit eng_rand;
    int eng_busy_len;
    int eng_cnt;

    // Reference model: queued bytes, sticky overflow, engine handshake phase
    // (0 free, 1 load pulse, 2 awaiting ready low, 3 awaiting ready high).
    logic [7:0] m_q[$];
    int         m_phase;
    logic       m_load;
    logic [7:0] m_data;
    logic       m_ovf;

    logic [7:0] got[$];
    int         ld_cyc[$];
    int         peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk({tname, ".tx_load"}, 32'(bus.tx_load), 32'(m_load));
        chk({tname, ".tx_data"}, 32'(bus.tx_data), 32'(m_data));
        chk({tname, ".count"},   32'(bus.count),   32'(m_q.size()));
        chk({tname, ".empty"},   32'(bus.empty),   32'(m_q.size() == 0));
        chk({tname, ".full"},    32'(bus.full),    32'(m_q.size() == DEPTH));
        chk({tname, ".ovf"},     32'(bus.ovf),     32'(m_ovf));
    endtask

    task automatic model_step();
        logic       pop;
        logic       dropped;
        logic [7:0] pb;
        pb      = 8'h00;
        dropped = 1'b0;
        pop     = (m_phase == 0) && (m_q.size() > 0) && (bus.tx_rdy == 1'b1);
        if (pop) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && bus.tx_rdy == 1'b0) begin
            m_phase = 3;
        end else if (m_phase == 3 && bus.tx_rdy == 1'b1) begin
            m_phase = 0;
        end
        if (pop) pb = m_q.pop_front();
        if (bus.wr_en && !bus.flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.wr_data);
            else dropped = 1'b1;
        end
        if (bus.flush) m_q.delete();
        if (dropped) m_ovf = 1'b1;
        else if (bus.ovf_clr) m_ovf = 1'b0;
        m_load = pop;
        if (pop) m_data = pb;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_load  = 1'b0;
        m_data  = 8'h00;
        m_ovf   = 1'b0;
        eng_cnt = 0;
    endtask

    // Engine model, input drive and model update for the coming rising edge.
    task automatic apply();
        if (eng_en) begin
            if (bus.tx_load === 1'b1) begin
                if (eng_rand) eng_busy_len = int'($urandom_range(2, 5));
                eng_cnt    = eng_busy_len;
                bus.tx_rdy = 1'b0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                bus.tx_rdy = (eng_cnt == 0);
            end else begin
                bus.tx_rdy = 1'b1;
            end
        end else begin
            bus.tx_rdy = s_rdy;
        end
        bus.wr_en   = s_wr;
        bus.wr_data = s_data;
        bus.flush   = s_flush;
        bus.ovf_clr = s_clr;
        model_step();
        s_wr    = 1'b0;
        s_flush = 1'b0;
        s_clr   = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (bus.tx_load === 1'b1) begin
            got.push_back(bus.tx_data);
            ld_cyc.push_back(cyc);
        end
        if (int'(bus.count) > peak) peak = int'(bus.count);
        apply();
    endtask

    task automatic release_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        model_reset();
        apply();
    endtask

    task automatic push(input logic [7:0] d);
        s_wr   = 1'b1;
        s_data = d;
        cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (m_phase == 0 && m_q.size() == 0) break;
            cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         g0;
        int         push_cyc;
        int         idx;
        int         n3c;
        logic [7:0] ov_bytes[16];
        logic [7:0] pat[40];
        logic [7:0] b;

        reset        = 1'b1;
        s_wr         = 1'b0;
        s_flush      = 1'b0;
        s_clr        = 1'b0;
        s_rdy        = 1'b1;
        s_data       = 8'h00;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.flush    = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.tx_rdy   = 1'b1;
        eng_en       = 1'b1;
        eng_rand     = 1'b0;
        eng_busy_len = 20;
        peak         = 0;
        model_reset();

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.tx_load", 32'(bus.tx_load), 32'd0);
        chk("rst.tx_data", 32'(bus.tx_data), 32'h00);
        chk("rst.count",   32'(bus.count),   32'd0);
        chk("rst.empty",   32'(bus.empty),   32'd1);
        chk("rst.full",    32'(bus.full),    32'd0);
        chk("rst.ovf",     32'(bus.ovf),     32'd0);
        release_reset();
        tname = "post_rst";
        repeat (2) cycle();

        // Single byte: minimum latency and no repeated load.
        tname = "single";
        g0 = got.size();
        push(8'hA5);
        push_cyc = cyc;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (cyc == push_cyc + 3) chk("single.empty_n3", 32'(bus.empty), 32'd1);
        end
        chk("single.loads", 32'(got.size() - g0), 32'd1);
        if (got.size() > g0) begin
            chk("single.data",     32'(got[g0]),    32'hA5);
            chk("single.load_cyc", 32'(ld_cyc[g0]), 32'(push_cyc + 2));
        end

        // Burst with back-pressure.
        tname = "burst";
        wait_idle();
        eng_busy_len = 10;
        g0   = got.size();
        peak = 0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        for (int i = 0; i < 300 && got.size() < g0 + 5; i++) cycle();
        chk("burst.loads", 32'(got.size() - g0), 32'd5);
        for (int i = 0; i < 5 && g0 + i < got.size(); i++)
            chk($sformatf("burst.byte%0d", i), 32'(got[g0+i]), 32'(i + 1));
        chk("burst.peak", 32'(peak == 4 || peak == 5), 32'd1);

        // Overflow with the engine held not-ready.
        tname = "ovf";
        wait_idle();
        eng_en = 1'b0;
        s_rdy  = 1'b0;
        cycle();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) ov_bytes[i] = b;
            push(b);
        end
        chk("ovf.full_after16",  32'(bus.full),  32'd1);
        chk("ovf.count_after16", 32'(bus.count), 32'd16);
        chk("ovf.ovf_before17",  32'(bus.ovf),   32'd0);
        cycle();
        chk("ovf.ovf_after17",   32'(bus.ovf),   32'd1);
        chk("ovf.count_after17", 32'(bus.count), 32'd16);
        s_clr = 1'b1;
        cycle();
        cycle();
        chk("ovf.cleared", 32'(bus.ovf), 32'd0);
        s_clr  = 1'b1;
        s_wr   = 1'b1;
        s_data = 8'hEE;
        cycle();
        cycle();
        chk("ovf.set_wins", 32'(bus.ovf),   32'd1);
        chk("ovf.count_hold", 32'(bus.count), 32'd16);

        // Wrap-around: drain from full while pushing an incrementing pattern.
        tname = "wrap";
        g0 = got.size();
        idx = int'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) pat[i] = 8'(idx + i);
        eng_en   = 1'b1;
        eng_rand = 1'b1;
        eng_cnt  = 0;
        push(pat[0]);
        cycle();
        chk("wrap.pushpop_load",  32'(bus.tx_load), 32'd1);
        chk("wrap.pushpop_count", 32'(bus.count),   32'd16);
        idx = 1;
        for (int i = 0; i < 3000 && got.size() < g0 + 56; i++) begin
            if (idx < 40 && $urandom_range(0, 1) == 1 && m_q.size() < DEPTH - 1) begin
                s_wr   = 1'b1;
                s_data = pat[idx];
                idx++;
            end
            cycle();
        end
        chk("wrap.loads", 32'(got.size() - g0), 32'd56);
        for (int i = 0; i < 56 && g0 + i < got.size(); i++)
            chk($sformatf("wrap.byte%0d", i), 32'(got[g0+i]),
                32'(i < 16 ? ov_bytes[i] : pat[i-16]));
        eng_rand = 1'b0;

        // Flush while the first byte is still with the engine.
        tname = "flush";
        wait_idle();
        eng_busy_len = 15;
        g0 = got.size();
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 100 && m_phase != 3; i++) cycle();
        s_flush = 1'b1;
        s_wr    = 1'b1;
        s_data  = 8'h3C;
        cycle();
        cycle();
        chk("flush.count", 32'(bus.count), 32'd0);
        chk("flush.empty", 32'(bus.empty), 32'd1);
        chk("flush.ovf",   32'(bus.ovf),   32'd1);
        repeat (40) cycle();
        chk("flush.loads", 32'(got.size() - g0), 32'd1);
        if (got.size() > g0) chk("flush.first", 32'(got[g0]), 32'h40);
        n3c = 0;
        for (int i = g0; i < got.size(); i++) if (got[i] == 8'h3C) n3c++;
        chk("flush.no3c", 32'(n3c), 32'd0);

        // Asynchronous reset while waiting on a stale ready level.
        tname = "areset";
        wait_idle();
        eng_en = 1'b0;
        s_rdy  = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push(8'(8'h81 + i));
        repeat (3) cycle();
        chk("areset.pre_count", 32'(bus.count),   32'd3);
        chk("areset.pre_data",  32'(bus.tx_data), 32'h81);
        chk("areset.pre_ovf",   32'(bus.ovf),     32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset.tx_load", 32'(bus.tx_load), 32'd0);
        chk("areset.tx_data", 32'(bus.tx_data), 32'h00);
        chk("areset.count",   32'(bus.count),   32'd0);
        chk("areset.empty",   32'(bus.empty),   32'd1);
        chk("areset.full",    32'(bus.full),    32'd0);
        chk("areset.ovf",     32'(bus.ovf),     32'd0);
        eng_en = 1'b1;
        release_reset();
        tname = "after_rst";
        g0 = got.size();
        cycle();
        push(8'h5A);
        repeat (10) cycle();
        chk("after_rst.loads", 32'(got.size() - g0), 32'd1);
        if (got.size() > g0) chk("after_rst.data", 32'(got[g0]), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
